// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller system side.
// Contents: bus direction encodings (CREAD/CWRITE), the default memory
// wait-state count, and the state encodings of the write buffer's front
// (cache side) and back (memory side) state machines.
package cache_pkg;

    localparam logic CREAD  = 1'b0;
    localparam logic CWRITE = 1'b1;

    // Nominal memory latency in cycles, used by memory-side models.
    localparam int WAITSTATES = 2;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WSTALL,
        F_FWD,
        F_RMISS
    } front_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WRITE,
        B_READ
    } back_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Posted-write storage for sys_write_buffer.
// Ports:
//   clk, rst (async, active-low)
//   push_i/push_addr_i/push_data_i : enqueue one address/data entry
//   pop_i                          : retire the head entry
//   head_addr_o/head_data_o        : oldest entry (next to drain)
//   count_o, full_o, empty_o       : occupancy
//   match_addr_i, hit_o, hit_data_o: associative lookup over all valid
//                                    entries, returning the youngest hit
module wb_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [PTR_W:0]    count_o,
    output logic              full_o,
    output logic              empty_o,
    input  logic [ADDR_W-1:0] match_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    // Entry storage carries no reset; validity comes from the pointers/count.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem[wr_ptr_q] <= push_addr_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Scan oldest to youngest so the last hit seen is the youngest one.
    // The head stays valid while its drain is in flight, so it is included.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_q) && (addr_mem[idx] == match_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_mem[idx];
            end
        end
    end

    assign head_addr_o = addr_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/sys_write_buffer.sv
// Posted-write buffer between the cache controller request port (S_*) and
// the backing memory bus (M_*). Writes are queued and acknowledged at once,
// then drained in order; read misses forward from the youngest buffered
// write to the same address, or go to memory ahead of queued drains.
// Ports:
//   clk, rst (async, active-low)
//   S_strobe/S_rw/S_addr/S_wdata : request in; S_rdata/S_ready : response
//   M_strobe/M_rw/M_addr/M_wdata : memory request (registered, held until
//                                  M_ready); M_rdata/M_ready : response
//   Buf_empty, Buf_full          : buffer status
module sys_write_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_strobe,
    input  logic              S_rw,
    input  logic [ADDR_W-1:0] S_addr,
    input  logic [DATA_W-1:0] S_wdata,
    output logic [DATA_W-1:0] S_rdata,
    output logic              S_ready,
    output logic              M_strobe,
    output logic              M_rw,
    output logic [ADDR_W-1:0] M_addr,
    output logic [DATA_W-1:0] M_wdata,
    input  logic [DATA_W-1:0] M_rdata,
    input  logic              M_ready,
    output logic              Buf_empty,
    output logic              Buf_full
);

    localparam int PTR_W = $clog2(DEPTH);

    front_state_e      f_q, f_d;
    back_state_e       b_q, b_d;
    logic              s_ready_q, s_ready_d;
    logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
    logic [ADDR_W-1:0] stall_addr_q, stall_addr_d;
    logic [DATA_W-1:0] stall_data_q, stall_data_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              m_strobe_q, m_strobe_d;
    logic              m_rw_q, m_rw_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic              push, pop, rd_req;
    logic [ADDR_W-1:0] push_addr, rd_addr, head_addr;
    logic [DATA_W-1:0] push_data, head_data, hit_data;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full, fifo_empty, fifo_hit;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_addr_i  (push_addr),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .match_addr_i (S_addr),
        .hit_o        (fifo_hit),
        .hit_data_o   (hit_data)
    );

    // The head retires exactly when memory completes its write.
    assign pop = (b_q == B_WRITE) && M_ready;

    // Front FSM. A read miss raises rd_req already in its strobe cycle so
    // an idle back end can start the memory read on the next edge.
    always_comb begin
        f_d          = f_q;
        s_ready_d    = 1'b0;
        s_rdata_d    = s_rdata_q;
        stall_addr_d = stall_addr_q;
        stall_data_d = stall_data_q;
        miss_addr_d  = miss_addr_q;
        push         = 1'b0;
        push_addr    = S_addr;
        push_data    = S_wdata;
        rd_req       = 1'b0;
        rd_addr      = miss_addr_q;
        case (f_q)
            F_IDLE: begin
                if (S_strobe) begin
                    if (S_rw == CWRITE) begin
                        // A pop in the same cycle frees the slot this write takes.
                        if (!fifo_full || pop) begin
                            push      = 1'b1;
                            s_ready_d = 1'b1;
                        end else begin
                            f_d          = F_WSTALL;
                            stall_addr_d = S_addr;
                            stall_data_d = S_wdata;
                        end
                    end else if (fifo_hit) begin
                        s_rdata_d = hit_data;
                        s_ready_d = 1'b1;
                        f_d       = F_FWD;
                    end else begin
                        rd_req      = 1'b1;
                        rd_addr     = S_addr;
                        miss_addr_d = S_addr;
                        f_d         = F_RMISS;
                    end
                end
            end
            F_WSTALL: begin
                push_addr = stall_addr_q;
                push_data = stall_data_q;
                if (!fifo_full || pop) begin
                    push      = 1'b1;
                    s_ready_d = 1'b1;
                    f_d       = F_IDLE;
                end
            end
            F_FWD: begin
                f_d = F_IDLE;
            end
            F_RMISS: begin
                rd_req = 1'b1;
                if ((b_q == B_READ) && M_ready) begin
                    s_rdata_d = M_rdata;
                    s_ready_d = 1'b1;
                    f_d       = F_IDLE;
                end
            end
            default: f_d = F_IDLE;
        endcase
    end

    // Back FSM. Bus outputs are registered and only change when a new
    // transfer starts, so they stay stable until M_ready.
    always_comb begin
        b_d        = b_q;
        m_strobe_d = m_strobe_q;
        m_rw_d     = m_rw_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        case (b_q)
            B_IDLE: begin
                if (rd_req) begin
                    b_d        = B_READ;
                    m_strobe_d = 1'b1;
                    m_rw_d     = CREAD;
                    m_addr_d   = rd_addr;
                end else if (!fifo_empty) begin
                    b_d        = B_WRITE;
                    m_strobe_d = 1'b1;
                    m_rw_d     = CWRITE;
                    m_addr_d   = head_addr;
                    m_wdata_d  = head_data;
                end
            end
            B_WRITE, B_READ: begin
                if (M_ready) begin
                    b_d        = B_IDLE;
                    m_strobe_d = 1'b0;
                end
            end
            default: b_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q          <= F_IDLE;
            b_q          <= B_IDLE;
            s_ready_q    <= 1'b0;
            s_rdata_q    <= '0;
            stall_addr_q <= '0;
            stall_data_q <= '0;
            miss_addr_q  <= '0;
            m_strobe_q   <= 1'b0;
            m_rw_q       <= CREAD;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
        end else begin
            f_q          <= f_d;
            b_q          <= b_d;
            s_ready_q    <= s_ready_d;
            s_rdata_q    <= s_rdata_d;
            stall_addr_q <= stall_addr_d;
            stall_data_q <= stall_data_d;
            miss_addr_q  <= miss_addr_d;
            m_strobe_q   <= m_strobe_d;
            m_rw_q       <= m_rw_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign S_ready   = s_ready_q;
    assign S_rdata   = s_rdata_q;
    assign M_strobe  = m_strobe_q;
    assign M_rw      = m_rw_q;
    assign M_addr    = m_addr_q;
    assign M_wdata   = m_wdata_q;
    assign Buf_full  = fifo_full;
    // A write still on the bus counts as buffered even after it is popped.
    assign Buf_empty = (fifo_count == '0) && (b_q != B_WRITE);

endmodule

// File: tb/tb_sys_write_buffer.sv
// Directed self-checking bench for sys_write_buffer: reset values, write
// acceptance and drain order, full-buffer stall, forwarding, read-miss
// ordering behind an in-flight write, and reset during a drain.
module tb_sys_write_buffer;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        S_strobe = 1'b0;
    logic        S_rw = CREAD;
    logic [31:0] S_addr = '0;
    logic [31:0] S_wdata = '0;
    logic [31:0] S_rdata;
    logic        S_ready;
    logic        M_strobe;
    logic        M_rw;
    logic [31:0] M_addr;
    logic [31:0] M_wdata;
    logic [31:0] M_rdata = '0;
    logic        M_ready = 1'b0;
    logic        Buf_empty;
    logic        Buf_full;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_rw   [$];
    int          mem_delay = WAITSTATES;
    int          wait_cnt  = 0;
    int          base;

    always #5 clk = ~clk;

    sys_write_buffer #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S_strobe  (S_strobe),
        .S_rw      (S_rw),
        .S_addr    (S_addr),
        .S_wdata   (S_wdata),
        .S_rdata   (S_rdata),
        .S_ready   (S_ready),
        .M_strobe  (M_strobe),
        .M_rw      (M_rw),
        .M_addr    (M_addr),
        .M_wdata   (M_wdata),
        .M_rdata   (M_rdata),
        .M_ready   (M_ready),
        .Buf_empty (Buf_empty),
        .Buf_full  (Buf_full)
    );

    // Memory model: answers each request after mem_delay extra cycles and
    // logs every completed transfer in order. Read data = addr ^ 0xDEAD0000.
    always begin
        @(posedge clk);
        #2;
        M_ready = 1'b0;
        if (rst && M_strobe) begin
            if (wait_cnt >= mem_delay) begin
                M_ready  = 1'b1;
                M_rdata  = M_addr ^ 32'hDEAD0000;
                log_addr.push_back(M_addr);
                log_data.push_back(M_wdata);
                log_rw.push_back(M_rw);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns 1 time unit after the sampling edge.
    task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d);
        S_strobe = 1'b1;
        S_rw     = rw;
        S_addr   = a;
        S_wdata  = d;
        tick();
        S_strobe = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!S_ready && n < budget) begin
            tick();
            n++;
        end
        chk1(tag, S_ready, 1'b1);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int n = 0;
        while (!(Buf_empty && !M_strobe) && n < budget) begin
            tick();
            n++;
        end
        chk1(tag, Buf_empty, 1'b1);
    endtask

    initial begin
        // Reset
        #2 rst = 1'b0;
        tick();
        tick();
        chk1 ("rst_s_ready",   S_ready,   1'b0);
        chk32("rst_s_rdata",   S_rdata,   32'h0);
        chk1 ("rst_m_strobe",  M_strobe,  1'b0);
        chk1 ("rst_m_rw",      M_rw,      CREAD);
        chk32("rst_m_addr",    M_addr,    32'h0);
        chk32("rst_m_wdata",   M_wdata,   32'h0);
        chk1 ("rst_buf_empty", Buf_empty, 1'b1);
        chk1 ("rst_buf_full",  Buf_full,  1'b0);
        rst = 1'b1;
        tick();

        // Single write, memory answers immediately
        mem_delay = 0;
        req(CWRITE, 32'h100, 32'hAAAA0001);
        chk1("t1_ack", S_ready, 1'b1);
        chk1("t1_not_empty", Buf_empty, 1'b0);
        tick();
        chk1 ("t1_ack_pulse", S_ready,  1'b0);
        chk1 ("t1_m_strobe",  M_strobe, 1'b1);
        chk1 ("t1_m_rw",      M_rw,     CWRITE);
        chk32("t1_m_addr",    M_addr,   32'h100);
        chk32("t1_m_wdata",   M_wdata,  32'hAAAA0001);
        tick();
        chk1 ("t1_empty_after", Buf_empty, 1'b1);
        chk32("t1_log_n",       32'(log_addr.size()), 32'd1);
        chk32("t1_log_addr",    log_addr[0], 32'h100);
        chk32("t1_log_data",    log_data[0], 32'hAAAA0001);

        // Fill the buffer with a slow memory, then stall the fifth write
        mem_delay = 5;
        base = log_addr.size();
        for (int i = 0; i < 4; i++) begin
            req(CWRITE, 32'(i * 4), 32'h1000 + 32'(i));
            chk1("t2_fast_ack", S_ready, 1'b1);
        end
        chk1("t2_full", Buf_full, 1'b1);
        req(CWRITE, 32'h10, 32'h1004);
        chk1("t2_stall_no_ack", S_ready, 1'b0);
        chk1("t2_stall_full", Buf_full, 1'b1);
        wait_ready("t2_stall_ack", 20);
        chk32("t2_ack_after_first_pop", 32'(log_addr.size() - base), 32'd1);
        chk1("t2_full_on_push_pop", Buf_full, 1'b1);
        tick();
        chk1("t2_ack_pulse", S_ready, 1'b0);
        wait_empty("t2_drained", 200);
        chk32("t2_log_n", 32'(log_addr.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk32("t2_order_addr", log_addr[base + i], 32'(i * 4));
            chk32("t2_order_data", log_data[base + i], 32'h1000 + 32'(i));
            chk1 ("t2_order_rw",   log_rw[base + i],   CWRITE);
        end

        // Forwarding from the youngest match and from the in-flight head
        mem_delay = 3;
        base = log_addr.size();
        req(CWRITE, 32'h20, 32'h1234);
        chk1("t3_ack1", S_ready, 1'b1);
        req(CWRITE, 32'h20, 32'h5678);
        chk1("t3_ack2", S_ready, 1'b1);
        req(CREAD, 32'h20, 32'h0);
        chk1 ("t3_fwd_ack",   S_ready, 1'b1);
        chk32("t3_fwd_data",  S_rdata, 32'h5678);
        tick();
        chk1("t3_fwd_pulse", S_ready, 1'b0);
        wait_empty("t3_drained", 100);
        chk32("t3_log_n", 32'(log_addr.size() - base), 32'd2);
        chk32("t3_data0", log_data[base],     32'h1234);
        chk32("t3_data1", log_data[base + 1], 32'h5678);
        chk1 ("t3_rw1",   log_rw[base + 1],   CWRITE);
        req(CWRITE, 32'h30, 32'hBEEF);
        chk1("t3_ack3", S_ready, 1'b1);
        tick();
        chk1("t3_head_in_flight", M_strobe, 1'b1);
        req(CREAD, 32'h30, 32'h0);
        chk1 ("t3_head_fwd_ack",  S_ready, 1'b1);
        chk32("t3_head_fwd_data", S_rdata, 32'hBEEF);
        tick();
        wait_empty("t3_drained2", 100);
        chk32("t3_no_mem_read", 32'(log_addr.size() - base), 32'd3);

        // Read miss behind an in-flight write with two writes queued
        mem_delay = 4;
        base = log_addr.size();
        req(CWRITE, 32'h0, 32'h11110000);
        chk1("t4_ack0", S_ready, 1'b1);
        req(CWRITE, 32'h50, 32'h55);
        chk1("t4_ack1", S_ready, 1'b1);
        req(CWRITE, 32'h60, 32'h66);
        chk1("t4_ack2", S_ready, 1'b1);
        req(CREAD, 32'h40, 32'h0);
        chk1("t4_miss_no_fast_ack", S_ready, 1'b0);
        wait_ready("t4_miss_ack", 80);
        chk32("t4_miss_data", S_rdata, 32'hDEAD0040);
        tick();
        chk1("t4_miss_pulse", S_ready, 1'b0);
        wait_empty("t4_drained", 200);
        chk32("t4_log_n",  32'(log_addr.size() - base), 32'd4);
        chk32("t4_addr0",  log_addr[base],     32'h0);
        chk1 ("t4_rw0",    log_rw[base],       CWRITE);
        chk32("t4_addr1",  log_addr[base + 1], 32'h40);
        chk1 ("t4_rw1",    log_rw[base + 1],   CREAD);
        chk32("t4_addr2",  log_addr[base + 2], 32'h50);
        chk32("t4_addr3",  log_addr[base + 3], 32'h60);
        chk32("t4_data3",  log_data[base + 3], 32'h66);

        // Reset in the middle of a drain
        mem_delay = 10;
        base = log_addr.size();
        req(CWRITE, 32'h70, 32'h70);
        req(CWRITE, 32'h74, 32'h74);
        req(CWRITE, 32'h78, 32'h78);
        chk1("t6_ack", S_ready, 1'b1);
        tick();
        chk1("t6_in_flight", M_strobe, 1'b1);
        rst = 1'b0;
        #1;
        chk1("t6_async_m_strobe", M_strobe,  1'b0);
        chk1("t6_async_empty",    Buf_empty, 1'b1);
        chk1("t6_async_full",     Buf_full,  1'b0);
        chk1("t6_async_s_ready",  S_ready,   1'b0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk1 ("t6_post_m_strobe", M_strobe,  1'b0);
        chk1 ("t6_post_empty",    Buf_empty, 1'b1);
        chk32("t6_no_writes",     32'(log_addr.size() - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_write_buffer.md
# sys_write_buffer

Posted-write buffer on the system side of the cache controller, between the controller's S_* request port and the backing memory bus (M_*). Write-through stores are queued and acknowledged in one cycle, then drained to memory in order while the processor continues. Read misses forward from the youngest matching buffered write, or go to memory ahead of any not-yet-started drain writes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- S_strobe  in  1  one-cycle request pulse from cache controller
- S_rw  in  1  CREAD/CWRITE, sampled with S_strobe
- S_addr  in  ADDR_W  request address, sampled with S_strobe
- S_wdata  in  DATA_W  write data, sampled with S_strobe
- S_rdata  out  DATA_W  read data, valid while S_ready
- S_ready  out  1  one-cycle completion pulse
- M_strobe  out  1  memory request, held until M_ready
- M_rw  out  1  CREAD/CWRITE
- M_addr  out  ADDR_W  memory address
- M_wdata  out  DATA_W  memory write data
- M_rdata  in  DATA_W  memory read data, valid with M_ready
- M_ready  in  1  memory completion, one cycle
- Buf_empty  out  1  no queued or in-flight writes
- Buf_full  out  1  DEPTH entries occupied

## Operation
- Reset values: S_ready 0, S_rdata 0, M_strobe 0, M_rw CREAD, M_addr 0, M_wdata 0, Buf_empty 1, Buf_full 0; FIFO pointers/count 0; both FSMs idle.
- Front FSM (cache side): F_IDLE, F_WSTALL, F_FWD, F_RMISS.
  - F_IDLE + write strobe, not full (or head pop this cycle) → enqueue, S_ready next cycle, stay F_IDLE.
  - F_IDLE + write strobe, full → F_WSTALL; request held; enqueue on cycle of head pop; S_ready next cycle; → F_IDLE.
  - F_IDLE + read strobe, address matches ≥1 entry (including in-flight head) → F_FWD; S_rdata = youngest match; S_ready next cycle; → F_IDLE.
  - F_IDLE + read strobe, no match → F_RMISS; raises read request to back FSM; on M_ready capture M_rdata, S_ready next cycle; → F_IDLE.
  - S_strobe outside F_IDLE is ignored (one outstanding request per protocol).
- Back FSM (memory side): B_IDLE, B_WRITE, B_READ.
  - Priority in B_IDLE: pending read miss > non-empty FIFO > idle.
  - B_WRITE: drives head entry; on M_ready pop head, → B_IDLE.
  - B_READ: drives CREAD at miss address; on M_ready → B_IDLE.
  - An in-flight write is never aborted; read miss waits for it.
- Ordering: drains in FIFO order; forwarding guarantees read-after-write correctness.
- Pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
- Buf_empty = count==0 and back FSM not in B_WRITE.
- Reset mid-operation: queued writes discarded, M_strobe drops asynchronously; no S_ready issued for interrupted request.

## Timing
- Write accept, not full: strobe edge N → S_ready at N+1.
- Forwarded read: S_ready and S_rdata at N+1.
- Read miss, memory idle: M_strobe from N+1; M_ready at cycle K → S_ready at K+1.
- Read miss behind in-flight write: M_strobe starts cycle after that write's M_ready.
- Enqueued write eligible to drain the cycle after enqueue.
- Simultaneous enqueue and pop: count unchanged, Buf_full unchanged.
- M_strobe, M_rw, M_addr, M_wdata registered, stable from assertion through M_ready.
- S_ready is exactly one cycle per request.

## Structure
- Shared cache_pkg: CREAD/CWRITE, WAITSTATES, front/back state enums.
- Sub-module wb_fifo: storage, pointers, count, full/empty, associative match returning youngest-hit data; front/back FSMs in top.

## Test plan
- Write 0x100/0xAAAA0001 with memory idle → S_ready next cycle; M_strobe CWRITE 0x100 next; Buf_empty 1 after M_ready.
- Memory M_ready delay 5, five writes 0x0,0x4,0x8,0xC,0x10 → first four ack in 1 cycle, Buf_full 1, fifth acks one cycle after first pop; memory sees in order.
- Write 0x20/0x1234, then 0x20/0x5678, then read 0x20 before drain → S_rdata 0x5678 at N+1, no memory read.
- Read miss 0x40 while write 0x0 in flight, two writes queued → memory sees write 0x0, read 0x40, then queued writes; S_rdata = M_rdata.
- Enqueue on same cycle as head pop with full buffer → accepted, S_ready next cycle, count stays DEPTH.
- rst low mid-drain with 3 entries → M_strobe 0 immediately; after release Buf_empty 1, no memory writes.
